vin_frame_writer: RTL and testbench

VIN_FRAME_WRITER -- requirements
Module: vin_frame_writer

---
 rtl/vin_frame_writer.sv | 175 +++++++++++++++++
 tb/tb_vin_frame_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vin_frame_writer.sv
// Video-input frame writer: aligns a pixel stream to vertical sync,
// handshakes with a frame buffer, writes clipped frames, flags bad geometry.
//
// Ports:
//   video_clk, rst            pixel clock, async active-high reset
//   vin_hs/vs/de/data         raw video input (hs is ignored)
//   write_req/write_req_ack   per-frame buffer handshake
//   write_en/write_data       pixel write stream (2 cycles after vin_de)
//   frame_active              a frame is being written
//   frame_drop/frame_err      one-cycle status pulses
//   frame_cnt                 completed frames (wraps)
module vin_frame_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int VS_POL     = 1
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  vin_hs,
    input  logic                  vin_vs,
    input  logic                  vin_de,
    input  logic [DATA_WIDTH-1:0] vin_data,
    output logic                  write_req,
    input  logic                  write_req_ack,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  frame_active,
    output logic                  frame_drop,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);

    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic        VS_ACT = (VS_POL != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  vs_d0;
    logic                  de_d0;
    logic                  de_d1;
    logic [DATA_WIDTH-1:0] data_d0;

    logic [10:0] pix_cnt;
    logic [10:0] line_cnt;
    logic        line_bad;

    logic fs;
    logic de_fall;
    logic active;
    logic enter_active;
    logic end_frame;
    logic drop_nxt;
    logic wr_ok;

    // hsync carries no information this block needs
    logic unused_hs;
    assign unused_hs = vin_hs;

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            vs_d0   <= 1'b0;
            de_d0   <= 1'b0;
            de_d1   <= 1'b0;
            data_d0 <= '0;
        end else begin
            vs_d0   <= vin_vs;
            de_d0   <= vin_de;
            de_d1   <= de_d0;
            data_d0 <= vin_data;
        end
    end

    // Frame start is the trailing edge of the vsync pulse
    assign fs      = (vs_d0 == VS_ACT) && (vin_vs != VS_ACT);
    assign de_fall = de_d1 && !de_d0;
    assign active  = (state == ACTIVE);

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        enter_active = 1'b0;
        end_frame    = 1'b0;
        drop_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fs) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // ack takes priority over a coincident frame start
                if (write_req_ack) begin
                    state_nxt    = ACTIVE;
                    enter_active = 1'b1;
                end else if (fs) begin
                    drop_nxt = 1'b1;
                end
            end
            ACTIVE: begin
                if (fs) begin
                    state_nxt = REQ;
                    end_frame = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign write_req    = (state == REQ);
    assign frame_active = active;

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_bad <= 1'b0;
        end else if (enter_active) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_bad <= 1'b0;
        end else begin
            // saturate so an overlong line can never wrap back into range
            if (de_fall) begin
                pix_cnt <= '0;
            end else if (active && de_d0 && pix_cnt != CNT_MAX) begin
                pix_cnt <= pix_cnt + 11'd1;
            end
            if (active && de_fall) begin
                if (line_cnt != CNT_MAX) begin
                    line_cnt <= line_cnt + 11'd1;
                end
                if (pix_cnt != H_LIM) begin
                    line_bad <= 1'b1;
                end
            end
        end
    end

    assign wr_ok = active && de_d0 && (pix_cnt < H_LIM) && (line_cnt < V_LIM);

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            write_en   <= 1'b0;
            write_data <= '0;
            frame_drop <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            write_en   <= wr_ok;
            write_data <= wr_ok ? data_d0 : '0;
            frame_drop <= drop_nxt;
            frame_err  <= end_frame && (line_bad || line_cnt != V_LIM);
            if (end_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vin_frame_writer.sv
// Testbench for vin_frame_writer: random pixel data and blanking,
// checked against a frame-level model of the expected write stream.
module tb_vin_frame_writer;

    localparam int DW = 16;
    localparam int H  = 16;
    localparam int V  = 6;

    logic          video_clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin_hs = 1'b0;
    logic          vin_vs = 1'b0;
    logic          vin_de = 1'b0;
    logic [DW-1:0] vin_data = '0;
    logic          write_req;
    logic          write_req_ack = 1'b0;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          frame_active;
    logic          frame_drop;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    always #5 video_clk = ~video_clk;

    vin_frame_writer #(
        .DATA_WIDTH(DW),
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .VS_POL(1)
    ) dut (
        .video_clk(video_clk),
        .rst(rst),
        .vin_hs(vin_hs),
        .vin_vs(vin_vs),
        .vin_de(vin_de),
        .vin_data(vin_data),
        .write_req(write_req),
        .write_req_ack(write_req_ack),
        .write_en(write_en),
        .write_data(write_data),
        .frame_active(frame_active),
        .frame_drop(frame_drop),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    // observed
    int n_wr = 0;
    int n_drop = 0;
    int n_err = 0;
    logic [DW-1:0] h0, h1;

    // reference model: 0 idle, 1 waiting for ack, 2 writing
    int m_state = 0;
    int m_lines = 0;
    bit m_bad = 0;
    logic [DW-1:0] exp_q[$];
    int exp_wr = 0;
    int exp_drop = 0;
    int exp_err = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    endtask

    always @(posedge video_clk) begin
        h1 <= h0;
        h0 <= vin_data;
    end

    always @(negedge video_clk) begin
        if (!rst) begin
            if (write_en) begin
                n_wr++;
                check("wdata_latency", write_data, h1);
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("wdata_order", write_data, exp_q.pop_front());
                end
            end else begin
                check("wdata_idle_zero", write_data, 0);
            end
            if (frame_drop) n_drop++;
            if (frame_err) n_err++;
        end
    end

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic enter_active();
        m_state = 2;
        m_lines = 0;
        m_bad = 0;
    endtask

    task automatic drive_line(input int len);
        for (int i = 0; i < len; i++) begin
            vin_de = 1'b1;
            vin_data = DW'($urandom);
            if (m_state == 2 && m_lines < V && i < H) begin
                exp_q.push_back(vin_data);
                exp_wr++;
            end
            tick();
        end
        if (m_state == 2) begin
            m_lines++;
            if (len != H) m_bad = 1;
        end
        vin_de = 1'b0;
        vin_data = DW'($urandom);
        repeat ($urandom_range(3, 6)) tick();
    endtask

    task automatic drive_frame(input int nlines, input int odd_line,
                               input int odd_len);
        for (int l = 0; l < nlines; l++) begin
            drive_line(l == odd_line ? odd_len : H);
        end
    endtask

    task automatic fs_pulse(input bit ack);
        vin_vs = 1'b1;
        tick();
        tick();
        vin_vs = 1'b0;
        write_req_ack = ack;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (ack) enter_active();
            else exp_drop++;
        end else begin
            if (m_bad || m_lines != V) exp_err++;
            exp_cnt = (exp_cnt + 1) & 16'hFFFF;
            m_state = 1;
        end
        tick();
        write_req_ack = 1'b0;
    endtask

    task automatic do_ack(input int delay);
        int t;
        t = 0;
        while (write_req !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("req_seen", write_req, 1);
        repeat (delay) tick();
        write_req_ack = 1'b1;
        enter_active();
        tick();
        write_req_ack = 1'b0;
        check("req_clear_after_ack", write_req, 0);
        check("active_after_ack", frame_active, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, write_req, 0);
        check({tag, "_wen"}, write_en, 0);
        check({tag, "_wdata"}, write_data, 0);
        check({tag, "_active"}, frame_active, 0);
        check({tag, "_drop"}, frame_drop, 0);
        check({tag, "_err"}, frame_err, 0);
        check({tag, "_cnt"}, frame_cnt, 0);
    endtask

    task automatic check_totals(input string tag);
        tick();
        tick();
        check({tag, "_writes"}, n_wr, exp_wr);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_drops"}, n_drop, exp_drop);
        check({tag, "_errs"}, n_err, exp_err);
        check({tag, "_fcnt"}, frame_cnt, exp_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_base;

        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        repeat (3) tick();

        // nominal frame
        fs_pulse(0);
        check("fs_req_next", write_req, 1);
        check("fs_not_active", frame_active, 0);
        do_ack(3);
        drive_frame(V, -1, 0);
        fs_pulse(0);
        check("nom_req_again", write_req, 1);
        check_totals("nominal");
        check("nom_writes", n_wr, H * V);
        check("nom_fcnt", frame_cnt, 1);

        // no ack across two frame starts
        wr_base = n_wr;
        drive_frame(V, -1, 0);
        fs_pulse(0);
        check("drop_pulse1", frame_drop, 1);
        tick();
        check("drop_one_cycle", frame_drop, 0);
        drive_frame(2, -1, 0);
        fs_pulse(0);
        check("drop_pulse2", frame_drop, 1);
        check("drop_req_held", write_req, 1);
        check_totals("drop");
        check("drop_no_writes", n_wr, wr_base);

        // short frame with one short line
        do_ack($urandom_range(0, 3));
        drive_frame(V - 1, 2, H - 1);
        fs_pulse(0);
        check("short_err_pulse", frame_err, 1);
        tick();
        check("short_err_one_cycle", frame_err, 0);
        check_totals("short");

        // one overlong line, clipped
        do_ack($urandom_range(0, 3));
        wr_base = n_wr;
        drive_frame(V, 1, H + 8);
        fs_pulse(0);
        check("long_err_pulse", frame_err, 1);
        check_totals("long");
        check("long_writes", n_wr - wr_base, H * V);

        // frame start and ack in the same cycle
        fs_pulse(1);
        check("coin_active", frame_active, 1);
        check("coin_req_low", write_req, 0);
        check("coin_no_drop", frame_drop, 0);
        drive_frame(V, -1, 0);
        fs_pulse(0);
        check("coin_no_err", frame_err, 0);
        check_totals("coincide");

        // reset in the middle of a line
        do_ack(1);
        drive_line(H);
        for (int i = 0; i < 5; i++) begin
            vin_de = 1'b1;
            vin_data = DW'($urandom);
            exp_q.push_back(vin_data);
            exp_wr++;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        exp_wr -= exp_q.size();
        exp_q.delete();
        m_state = 0;
        exp_cnt = 0;
        @(posedge video_clk);
        #1;
        check_zero("midrst_hold");
        rst = 1'b0;
        wr_base = n_wr;
        for (int i = 0; i < 6; i++) begin
            vin_data = DW'($urandom);
            tick();
        end
        vin_de = 1'b0;
        repeat (4) tick();
        drive_frame(2, -1, 0);
        fs_pulse(0);
        drive_frame(2, -1, 0);
        check("rst_no_writes", n_wr, wr_base);
        check("rst_fcnt_zero", frame_cnt, 0);
        do_ack(2);
        drive_frame(V, -1, 0);
        fs_pulse(0);
        check_totals("after_rst");
        check("after_rst_fcnt", frame_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
